// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle between the register-file requesters and rf_write_arbiter.
// The conflict signal exists only when RFARB_CONFLICT_CHK_EN is defined.
interface rf_write_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               Ld;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      Ds;
  logic               busy;
`ifdef RFARB_CONFLICT_CHK_EN
  logic               conflict;

  modport master (
    output req, req_addr, req_data,
    input  gnt, Ld, wr_addr, Ds, busy, conflict
  );
  modport slave (
    input  req, req_addr, req_data,
    output gnt, Ld, wr_addr, Ds, busy, conflict
  );
`else
  modport master (
    output req, req_addr, req_data,
    input  gnt, Ld, wr_addr, Ds, busy
  );
  modport slave (
    input  req, req_addr, req_data,
    output gnt, Ld, wr_addr, Ds, busy
  );
`endif
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, fully registered outputs.
// Optional RFARB_CONFLICT_CHK_EN adds a sticky same-address conflict flag.
module rf_write_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input logic              clk,
  input logic              reset,
  rf_write_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(NREQ);

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            ld_q, ld_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   ds_q, ds_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0] eligible;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     scan_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // Last cycle's grant is masked so a requester still dropping req is not granted twice.
  assign eligible = bus.req & ~gnt_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      scan_idx = {1'b0, ptr_q} + (PW + 1)'(j);
      if (scan_idx >= (PW + 1)'(NREQ)) begin
        scan_idx = scan_idx - (PW + 1)'(NREQ);
      end
      if (!win_found && eligible[scan_idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PW-1:0];
      end
    end
  end

  assign win_addr = bus.req_addr[win_idx*AW +: AW];
  assign win_data = bus.req_data[win_idx*DW +: DW];

  always_comb begin
    gnt_d  = '0;
    ld_d   = 1'b0;
    addr_d = addr_q;
    ds_d   = ds_q;
    ptr_d  = ptr_q;
    busy_d = ($countones(eligible) > 1);
    if (win_found) begin
      gnt_d[win_idx] = 1'b1;
      addr_d         = win_addr;
      ds_d           = win_data;
      // Writes to the zero register release the requester but never pulse Ld.
      ld_d           = |win_addr;
      ptr_d          = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q  <= '0;
      ld_q   <= 1'b0;
      addr_q <= '0;
      ds_q   <= '0;
      busy_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      gnt_q  <= gnt_d;
      ld_q   <= ld_d;
      addr_q <= addr_d;
      ds_q   <= ds_d;
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.Ld      = ld_q;
  assign bus.wr_addr = addr_q;
  assign bus.Ds      = ds_q;
  assign bus.busy    = busy_q;

`ifdef RFARB_CONFLICT_CHK_EN
  logic conflict_q, conflict_d;
  logic same_addr_hit;

  always_comb begin
    same_addr_hit = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = i + 1; j < NREQ; j++) begin
        if (eligible[i] && eligible[j] &&
            (bus.req_addr[i*AW +: AW] == bus.req_addr[j*AW +: AW]) &&
            (|bus.req_addr[i*AW +: AW])) begin
          same_addr_hit = 1'b1;
        end
      end
    end
    conflict_d = conflict_q | same_addr_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign bus.conflict = conflict_q;
`endif
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 32-bit register file among NREQ requesters (e.g. ALU writeback, load return, link-register write, MOV/exception path).
- Drives the Ld/address/data inputs of the register32 array through the file's write decoder.
- Grants, write enable, address and data all leave through one registered stage, so the register file sees clean, single-cycle write pulses.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- DW, 32, data width of each write.
- AW, 5, register address width; address 0 is the hardwired-zero register.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  NREQ  write request per requester; held high until grant is seen.
- req_addr  input  NREQ*AW  flattened destination addresses; slice i = [i*AW +: AW].
- req_data  input  NREQ*DW  flattened write data; slice i = [i*DW +: DW].
- gnt  output  NREQ  registered one-hot grant; pulses for one cycle per accepted write.
- Ld  output  1  registered write enable to the register file decoder.
- wr_addr  output  AW  registered destination address.
- Ds  output  DW  registered write data.
- busy  output  1  registered; high when at least one request was left ungranted last edge.

Behaviour:
- Reset values: gnt=0, Ld=0, wr_addr=0, Ds=0, busy=0, round-robin pointer ptr=0. Reset overrides any request in the same edge; no write is issued.
- Eligible set: eligible[i] = req[i] & ~gnt[i]. Masking the previous cycle's grant prevents a double grant while a requester is still dropping req.
  - Consequence: one requester receives at most one grant every 2 cycles.
  - With two or more requesters active, the port sustains 1 write/cycle.
- Selection:
  - Scan starts at index ptr and wraps modulo NREQ (ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1).
  - The first eligible index k wins.
- On an edge with a winner k:
  - gnt <= one-hot(k); wr_addr <= slice k of req_addr; Ds <= slice k of req_data; ptr <= (k+1) mod NREQ.
  - Ld <= 1 only if slice k of req_addr != 0.
  - A write to address 0 is still granted (the requester is released) but Ld stays 0 and the register file is untouched.
- On an edge with no eligible request:
  - gnt <= 0, Ld <= 0, ptr unchanged.
  - wr_addr and Ds hold their previous values.
- busy <= 1 when the number of eligible requests sampled at the edge is greater than 1, else 0.
- Latency:
  - Request sampled at edge E gives gnt/Ld/wr_addr/Ds valid in cycle E..E+1.
  - The register file captures Ds at edge E+1.
- Requester contract:
  - Keep req, addr and data stable until the cycle gnt[i] is high.
  - In that cycle, either drop req or present the next write; the next write is considered no earlier than the following edge.
- Boundaries:
  - ptr wraps from NREQ-1 to 0.
  - All requesters high continuously gives grant order 0,1,2,3,0,...
  - A single requester held high gets grant, gap, grant, gap, ...
- Reset mid-operation: pending requests are forgotten; requesters that are still high compete again from ptr=0 after reset deasserts.

Optional Feature:
- Macro RFARB_CONFLICT_CHK_EN.
- When defined:
  - Adds output conflict (1 bit, registered, sticky, cleared only by reset).
  - conflict sets when two or more eligible requests in the same edge target the same nonzero address.
  - Arbitration is unchanged.
- When undefined: the port and all associated logic are absent; there is no behavioural difference otherwise.

Test Plan:
- Reset, then drive all four requesters: req=4'b1111 held with addr 1,2,3,4 and data 32'hA0..A3 -> gnt 0001, 0010, 0100, 1000 on consecutive cycles; Ld=1 each cycle; wr_addr/Ds match; busy=1.
- Requester 2 only, held high with addr 7, data 32'h12345678 -> gnt=0100 every other cycle, wr_addr=7, Ds=32'h12345678, Ld toggles 1/0; busy=0.
- Requester 1 writes addr 0 with data 32'hFFFFFFFF -> gnt=0010, Ld=0; next request from 3 is granted with ptr=2 scan order.
- Grant to 3, then req=4'b1001 -> next winner 0 (wrap); ptr becomes 1.
- Assert reset for one edge while req=4'b0110 -> outputs all 0 after that edge; after release, first grant is 0010.
- RFARB_CONFLICT_CHK_EN: req 0 and 1 both to addr 5 -> conflict=1 and stays 1 until reset; both writes granted in order 0, then 1.
